// File: rtl/prog_loader_ctrl.sv
// rtl/prog_loader_ctrl.sv - boot-time program loader: byte stream -> imem lines / dmem words
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   rx_data/rx_valid  incoming program byte; rx_ready = byte accepted this cycle
//   ADDR, DATA        byte address and data of the current write
//   WE_128            one-cycle imem line write strobe (DATA = full 128-bit line)
//   WE_32             one-cycle dmem word write strobe (DATA[127:96] = word)
//   DONE              load complete, sticky until reset
//   ERR               header rejected, load aborted, sticky until reset
//
// Stream layout: NI, ND (little-endian 32-bit words), then NI imem words,
// then ND dmem words.

module prog_loader_ctrl #(
  parameter int IMEM_LINES = 512,
  parameter int DMEM_WORDS = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [31:0]  ADDR,
  output logic [127:0] DATA,
  output logic         WE_32,
  output logic         WE_128,
  output logic         DONE,
  output logic         ERR
);

  typedef enum logic [2:0] {
    S_HDR_I, S_HDR_D, S_LOAD_I, S_LOAD_D, S_FIN, S_ERR
  } state_t;

  state_t         state, state_next;
  logic [1:0]     byte_idx;
  logic [23:0]    word_sr;      // first three bytes of the word in flight
  logic [31:0]    ni, nd;
  logic [31:0]    word_cnt;
  logic [31:0]    line_cnt;
  logic [127:0]   line_buf;
  logic [31:0]    addr_q;
  logic [127:0]   data_q;
  logic           we32_q, we128_q, done_q;

  logic           ready_st, accept, word_done;
  logic [31:0]    word;
  logic           last_i, last_d, line_done, hdr_reject;
  logic [33:0]    lines_needed;
  logic [127:0]   line_next;

  assign ready_st  = (state == S_HDR_I) || (state == S_HDR_D) ||
                     (state == S_LOAD_I) || (state == S_LOAD_D);
  assign rx_ready  = ready_st & ~reset;
  assign accept    = rx_valid & rx_ready;
  assign word_done = accept & (byte_idx == 2'd3);
  assign word      = {rx_data, word_sr};

  assign last_i    = (word_cnt + 32'd1) == ni;
  assign last_d    = (word_cnt + 32'd1) == nd;
  assign line_done = (word_cnt[1:0] == 2'd3) || last_i;

  // 34-bit so ceil(NI/4) cannot wrap for NI near 2^32
  assign lines_needed = ({2'b00, ni} + 34'd3) >> 2;
  // evaluated while the ND word is completing, so ND is the live word
  assign hdr_reject   = (lines_needed > 34'(IMEM_LINES)) || (word > 32'(DMEM_WORDS));

  // word k of a line lands in the top-down slot DATA[127-32k -: 32]
  always_comb begin
    line_next = line_buf;
    case (word_cnt[1:0])
      2'd0:    line_next[127:96] = word;
      2'd1:    line_next[95:64]  = word;
      2'd2:    line_next[63:32]  = word;
      default: line_next[31:0]   = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_HDR_I;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_HDR_I:  if (word_done) state_next = S_HDR_D;
      S_HDR_D:  if (word_done) begin
                  if (hdr_reject)     state_next = S_ERR;
                  else if (ni != 0)   state_next = S_LOAD_I;
                  else if (word != 0) state_next = S_LOAD_D;
                  else                state_next = S_FIN;
                end
      S_LOAD_I: if (word_done && last_i) state_next = (nd != 0) ? S_LOAD_D : S_FIN;
      S_LOAD_D: if (word_done && last_d) state_next = S_FIN;
      S_FIN:    state_next = S_FIN;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_HDR_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx <= 2'd0;
      word_sr  <= '0;
      ni       <= '0;
      nd       <= '0;
      word_cnt <= '0;
      line_cnt <= '0;
      line_buf <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we32_q   <= 1'b0;
      we128_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      we32_q  <= 1'b0;
      we128_q <= 1'b0;

      // An empty load has no final strobe to wait behind, so DONE rises
      // right after the header; otherwise it trails the final strobe by one.
      if ((state == S_HDR_D && state_next == S_FIN) || state == S_FIN)
        done_q <= 1'b1;

      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_sr[7:0]   <= rx_data;
          2'd1:    word_sr[15:8]  <= rx_data;
          2'd2:    word_sr[23:16] <= rx_data;
          default: ;
        endcase
      end

      if (word_done) begin
        case (state)
          S_HDR_I: ni <= word;
          S_HDR_D: nd <= word;
          S_LOAD_I: begin
            if (line_done) begin
              we128_q  <= 1'b1;
              addr_q   <= line_cnt << 4;
              data_q   <= line_next;
              line_buf <= '0;          // keeps unfilled slots of a short last line zero
              line_cnt <= line_cnt + 32'd1;
            end else begin
              line_buf <= line_next;
            end
            // dmem indexing restarts at 0 after the imem section
            word_cnt <= last_i ? 32'd0 : word_cnt + 32'd1;
          end
          S_LOAD_D: begin
            we32_q   <= 1'b1;
            addr_q   <= word_cnt << 2;
            data_q   <= {word, 96'h0};
            word_cnt <= word_cnt + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs read as zero throughout reset, including the first reset cycle.
  assign ADDR   = reset ? 32'h0  : addr_q;
  assign DATA   = reset ? 128'h0 : data_q;
  assign WE_32  = we32_q  & ~reset;
  assign WE_128 = we128_q & ~reset;
  assign DONE   = done_q  & ~reset;
  assign ERR    = (state == S_ERR) & ~reset;

endmodule
